// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ clients.
// Captures the winner's character, pulses tx_start, then tracks tx_busy until the frame is sent.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 7,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        done,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    err,
    output logic                    active
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   grant_reg, grant_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               tx_start_reg, tx_start_next;
    logic [DATA_W-1:0]  tx_data_reg, tx_data_next;
    logic               err_reg, err_next;
    logic               active_reg, active_next;

    logic [DATA_W-1:0]  data_arr [N_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     scan_sum;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   ptr_after;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First requester at or after ptr, wrapping modulo N_REQ (works for non-power-of-two N_REQ).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // The last winner becomes lowest priority for the next round.
    assign ptr_after = (grant_reg == LAST_IDX) ? '0 : grant_reg + IDX_W'(1);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        grant_next    = grant_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        done_next     = '0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    ack_next[win_idx] = 1'b1;
                    tx_data_next      = data_arr[win_idx];
                    grant_next        = win_idx;
                    state_next        = START;
                end
            end
            START: begin
                tx_start_next = 1'b1;
                cnt_next      = '0;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A busy seen on the final count still counts as a successful start.
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CNT_MAX) begin
                    err_next   = 1'b1;
                    ptr_next   = ptr_after;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_next[grant_reg] = 1'b1;
                    ptr_next             = ptr_after;
                    state_next           = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        active_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            done_reg     <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            err_reg      <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            grant_reg    <= grant_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            done_reg     <= done_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
            err_reg      <= err_next;
            active_reg   <= active_next;
        end
    end

    assign ack      = ack_reg;
    assign done     = done_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign err      = err_reg;
    assign active   = active_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester clients and a UART busy model driven cycle by cycle,
// every output compared against a transaction-level timeline derived from the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 7;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic            err;
    logic            active;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    int n_txn    = 0;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .err      (err),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {21'd0, ack, done, tx_start, err, active};
    endfunction

    function automatic logic [31:0] ctl_exp(input logic [N-1:0] a, input logic [N-1:0] d,
                                            input logic s, input logic e, input logic act);
        return {21'd0, a, d, s, e, act};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round robin: first requester found scanning p, p+1, ... modulo N.
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int i, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_data[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] get_data(input int i);
        return req_data[i*DW +: DW];
    endfunction

    // Random client activity while the arbiter is busy; data only changes when a request is newly raised.
    task automatic churn();
        int i;
        i = $urandom_range(0, N-1);
        case ($urandom_range(0, 7))
            0, 1: if (!req[i]) raise(i, DW'($urandom));
            2:    req[i] = 1'b0;
            default: ;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_eq("idle", ctl_vec(), 32'd0);
        end
    endtask

    // One transfer, entered at a negedge with the DUT idle and req already driven.
    // Cycle c is observed at the c-th negedge after the arbitration edge.
    // r<0: UART never responds (timeout); else tx_busy is high in cycles r .. r+len-1.
    task automatic run_txn(input int r, input int len, input logic [N-1:0] rereq,
                           input bit do_churn, input int abort_at);
        int w;
        int end_c;
        bit to;
        logic [DW-1:0] exp_data;
        w = rr_pick(req, m_ptr);
        if (w < 0) begin
            n_errors++;
            $display("FAIL setup: no pending request at t=%0t", $time);
            return;
        end
        to       = (r < 0);
        end_c    = to ? TO + 2 : r + len + 1;
        exp_data = get_data(w);
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            check_eq("ctl", ctl_vec(),
                     ctl_exp((c == 1) ? onehot(w) : '0,
                             (!to && c == end_c) ? onehot(w) : '0,
                             c == 2, to && c == end_c, c < end_c));
            check_eq("tx_data", 32'(tx_data), 32'(exp_data));
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_eq("rst_ctl", ctl_vec(), 32'd0);
                check_eq("rst_data", 32'(tx_data), 32'd0);
                tx_busy = 1'b0;
                req     = '0;
                m_ptr   = 0;
                @(negedge clk);
                check_eq("rst_hold", ctl_vec(), 32'd0);
                rst = 1'b1;
                n_txn++;
                $display("txn %0d: winner %0d aborted by reset in cycle %0d", n_txn, w, c);
                return;
            end
            if (c == 1) begin
                req[w] = 1'b0;
                if (rereq[w]) raise(w, DW'($urandom));
            end else if (do_churn) begin
                churn();
            end
            tx_busy = (!to && c >= r && c < r + len);
        end
        m_ptr = (w + 1) % N;
        n_txn++;
        if (to)
            $display("txn %0d: winner %0d data %h timeout err in cycle %0d", n_txn, w, exp_data, end_c);
        else
            $display("txn %0d: winner %0d data %h done in cycle %0d", n_txn, w, exp_data, end_c);
    endtask

    initial begin
        int r;
        int len;
        int guard;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("reset_ctl", ctl_vec(), 32'd0);
        check_eq("reset_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_cycles(2);

        // Single request, busy rises three cycles after tx_start and lasts 20 cycles.
        raise(1, 7'h41);
        run_txn(5, 20, '0, 1'b0, 0);
        idle_cycles(1);

        // All four requesting at once.
        for (int i = 0; i < N; i++) raise(i, DW'($urandom));
        repeat (4) run_txn(3, 10, '0, 1'b0, 0);
        idle_cycles(2);

        // Two persistent requesters must alternate.
        raise(0, DW'($urandom));
        raise(2, DW'($urandom));
        repeat (6) run_txn(2, 4, 4'b0101, 1'b0, 0);
        req = '0;
        idle_cycles(1);

        // Timeout, then the search resumes at index 1.
        raise(0, DW'($urandom));
        run_txn(-1, 0, '0, 1'b0, 0);
        raise(0, DW'($urandom));
        raise(1, DW'($urandom));
        run_txn(2, 3, '0, 1'b0, 0);
        run_txn(2, 3, '0, 1'b0, 0);

        // Busy appears on the last allowed cycle; busy already high during START.
        raise(2, DW'($urandom));
        run_txn(TO + 1, 2, '0, 1'b0, 0);
        raise(3, DW'($urandom));
        run_txn(1, 4, '0, 1'b0, 0);
        idle_cycles(1);

        // Reset during WAIT_DONE, then a normal grant.
        raise(1, DW'($urandom));
        run_txn(3, 10, '0, 1'b0, 6);
        raise(3, DW'($urandom));
        run_txn(2, 5, '0, 1'b0, 0);

        // Pointer wrap after serving index 3.
        raise(0, DW'($urandom));
        raise(3, DW'($urandom));
        run_txn(2, 3, '0, 1'b0, 0);
        run_txn(2, 3, '0, 1'b0, 0);
        idle_cycles(1);

        // Randomized traffic with request churn in non-idle states.
        for (int t = 0; t < 60; t++) begin
            guard = 0;
            while (req == '0 && guard < 20) begin
                if ($urandom_range(0, 2) == 0) begin
                    raise($urandom_range(0, N-1), DW'($urandom));
                end else begin
                    @(negedge clk);
                    check_eq("idle", ctl_vec(), 32'd0);
                    guard++;
                end
            end
            if (req == '0) raise(0, DW'($urandom));
            r   = $urandom_range(1, TO + 1);
            len = $urandom_range(2, 12);
            if ($urandom_range(0, 7) == 0) r = -1;
            run_txn(r, len, N'($urandom), 1'b1, 0);
        end
        req = '0;
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule
